// File: rtl/flash_bus_arbiter.sv
// flash_bus_arbiter: gives one of two flash masters exclusive ownership of
// the shared SPI/QSPI pin set. Requester 0 is the flash_spi bridge and
// requester 1 is the QSPI controller.
// CS is held high for a guard interval between owners. oSEL/oBUS_EN tell the
// top level which master drives the SCK/data pins.
// Optional build macro: FLASH_ARB_PREEMPT_EN adds a hold counter. The counter
// raises oPREEMPT[n] when the owner has kept the bus for MAX_HOLD cycles while
// the other requester was waiting. The arbiter still never revokes a grant.

module flash_bus_arbiter #(
    parameter int unsigned GUARD_CYC = 4,    // 1..255
    parameter int unsigned MAX_HOLD  = 4096  // 16..65535
) (
    input  logic       iCLK,
    input  logic       iRESETn,
    input  logic [1:0] iREQ,
    input  logic [1:0] iCS_n,
    input  logic [1:0] iSCK,
    output logic [1:0] oGNT,
    output logic       oSEL,
    output logic       oBUS_EN,
    output logic       oFLASH_CSn,
    output logic       oFLASH_SCK,
    output logic [1:0] oPREEMPT
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StOwn0  = 2'd1,
        StOwn1  = 2'd2,
        StGuard = 2'd3
    } arbState_t;

    // The counter runs GUARD_CYC-1 down to 0. One IDLE cycle follows it.
    // This gives GUARD_CYC+1 CS-high cycles from the release edge to the next grant edge.
    localparam logic [7:0]  GuardLoad = 8'(GUARD_CYC - 1);
    localparam logic [15:0] HoldLimit = 16'(MAX_HOLD);

    arbState_t  stateQ, stateD;
    logic       lastServedQ, lastServedD;
    logic [7:0] guardCntQ, guardCntD;
    logic       selQ, selD;

    // State register. Reset forces IDLE, which drives CS high asynchronously.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            stateQ      <= StIdle;
            lastServedQ <= 1'b1;  // requester 0 wins the first tie
            guardCntQ   <= 8'd0;
            selQ        <= 1'b0;
        end else begin
            stateQ      <= stateD;
            lastServedQ <= lastServedD;
            guardCntQ   <= guardCntD;
            selQ        <= selD;
        end
    end

    // Next-state logic: round-robin arbitration, release handshake, guard countdown.
    always_comb begin
        stateD      = stateQ;
        lastServedD = lastServedQ;
        guardCntD   = guardCntQ;
        selD        = selQ;
        unique case (stateQ)
            StIdle: begin
                // On a tie, the requester that was not served last wins.
                if (iREQ[0] && (!iREQ[1] || lastServedQ)) begin
                    stateD = StOwn0;
                    selD   = 1'b0;
                end else if (iREQ[1]) begin
                    stateD = StOwn1;
                    selD   = 1'b1;
                end
            end
            StOwn0: begin
                // The owner is released only when its CS is high.
                // This avoids truncating a flash command in flight.
                if (!iREQ[0] && iCS_n[0]) begin
                    stateD      = StGuard;
                    lastServedD = 1'b0;
                    guardCntD   = GuardLoad;
                end
            end
            StOwn1: begin
                if (!iREQ[1] && iCS_n[1]) begin
                    stateD      = StGuard;
                    lastServedD = 1'b1;
                    guardCntD   = GuardLoad;
                end
            end
            StGuard: begin
                // Requests raised here stay pending and are picked up in IDLE.
                if (guardCntQ == 8'd0) begin
                    stateD = StIdle;
                end else begin
                    guardCntD = guardCntQ - 8'd1;
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // Pin gating: the owner's CS/SCK pass straight through. Otherwise CS is high and SCK is low.
    always_comb begin
        oGNT       = 2'b00;
        oFLASH_CSn = 1'b1;
        oFLASH_SCK = 1'b0;
        unique case (stateQ)
            StOwn0: begin
                oGNT       = 2'b01;
                oFLASH_CSn = iCS_n[0];
                oFLASH_SCK = iSCK[0];
            end
            StOwn1: begin
                oGNT       = 2'b10;
                oFLASH_CSn = iCS_n[1];
                oFLASH_SCK = iSCK[1];
            end
            default: begin
                oGNT       = 2'b00;
                oFLASH_CSn = 1'b1;
                oFLASH_SCK = 1'b0;
            end
        endcase
    end

    // oSEL keeps the last owner through GUARD/IDLE so the data-pin mux does not glitch.
    assign oSEL    = selQ;
    assign oBUS_EN = |oGNT;

`ifdef FLASH_ARB_PREEMPT_EN
    logic [15:0] holdCntQ, holdCntD;

    // Hold counter register.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            holdCntQ <= 16'd0;
        end else begin
            holdCntQ <= holdCntD;
        end
    end

    // Count owner cycles while the other side waits. The count is cleared
    // outside ownership, so it starts at 0 on every new grant. It saturates
    // instead of wrapping.
    always_comb begin
        holdCntD = holdCntQ;
        unique case (stateQ)
            StOwn0: begin
                if (iREQ[1] && (holdCntQ != 16'hFFFF)) begin
                    holdCntD = holdCntQ + 16'd1;
                end
            end
            StOwn1: begin
                if (iREQ[0] && (holdCntQ != 16'hFFFF)) begin
                    holdCntD = holdCntQ + 16'd1;
                end
            end
            default: begin
                holdCntD = 16'd0;
            end
        endcase
    end

    // The count cannot drop during ownership, so the request stays high until release.
    assign oPREEMPT[0] = (stateQ == StOwn0) && (holdCntQ >= HoldLimit);
    assign oPREEMPT[1] = (stateQ == StOwn1) && (holdCntQ >= HoldLimit);
`else
    logic unusedMaxHold;
    assign unusedMaxHold = ^HoldLimit;
    assign oPREEMPT      = 2'b00;
`endif

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Bench for flash_bus_arbiter. Grant checks use an expected-grant queue:
// an entry is pushed when a request is driven and popped when a grant appears.
module tb_flash_bus_arbiter;

    localparam int unsigned GuardCyc = 4;
    localparam int unsigned MaxHold  = 16;
    localparam int          MaxTxn   = 20;
    localparam int          WaitBound = MaxTxn + 2 * GuardCyc + 8;
`ifdef FLASH_ARB_PREEMPT_EN
    localparam bit PreemptOn = 1'b1;
`else
    localparam bit PreemptOn = 1'b0;
`endif

    logic       wMEM_CLK = 1'b0;
    logic       rRESETn;
    logic [1:0] rREQ;
    logic [1:0] rCS_n;
    logic [1:0] rSCK;
    logic [1:0] wGNT;
    logic       wSEL;
    logic       wBUS_EN;
    logic       wFLASH_CSn;
    logic       wFLASH_SCK;
    logic [1:0] wPREEMPT;

    int total = 0;
    int bad   = 0;
    logic [1:0] expQ[$];

    always #5 wMEM_CLK = ~wMEM_CLK;

    flash_bus_arbiter #(
        .GUARD_CYC (GuardCyc),
        .MAX_HOLD  (MaxHold)
    ) dut (
        .iCLK       (wMEM_CLK),
        .iRESETn    (rRESETn),
        .iREQ       (rREQ),
        .iCS_n      (rCS_n),
        .iSCK       (rSCK),
        .oGNT       (wGNT),
        .oSEL       (wSEL),
        .oBUS_EN    (wBUS_EN),
        .oFLASH_CSn (wFLASH_CSn),
        .oFLASH_SCK (wFLASH_SCK),
        .oPREEMPT   (wPREEMPT)
    );

    task automatic tick();
        @(posedge wMEM_CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Waits (bounded) for a grant. Also counts pre-grant cycles with the gated CS high.
    task automatic waitGrant(output int waited, output int csHigh);
        waited = 0;
        csHigh = 0;
        do begin
            tick();
            waited++;
            if (wGNT == 2'b00 && wFLASH_CSn) csHigh++;
        end while (wGNT == 2'b00 && waited < 50);
    endtask

    task automatic test_reset();
        rRESETn = 1'b0;
        rREQ    = 2'b00;
        rCS_n   = 2'b11;
        rSCK    = 2'b00;
        #12;
        total++; if (wGNT !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", wGNT); end
        total++; if (wSEL !== 1'b0) begin bad++; $display("FAIL reset_sel got=%b want=0", wSEL); end
        total++; if (wBUS_EN !== 1'b0) begin bad++; $display("FAIL reset_busen got=%b want=0", wBUS_EN); end
        total++; if (wFLASH_CSn !== 1'b1) begin bad++; $display("FAIL reset_csn got=%b want=1", wFLASH_CSn); end
        total++; if (wFLASH_SCK !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b want=0", wFLASH_SCK); end
        total++; if (wPREEMPT !== 2'b00) begin bad++; $display("FAIL reset_preempt got=%b want=00", wPREEMPT); end
        #3;
        rRESETn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int w, c;
        logic [1:0] e;
        ticks(5);
        rREQ = 2'b01;
        expQ.push_back(2'b01);
        waitGrant(w, c);
        e = expQ.pop_front();
        total++; if (wGNT !== e) begin bad++; $display("FAIL basic_gnt got=%b want=%b", wGNT, e); end
        total++; if (w != 1) begin bad++; $display("FAIL basic_latency got=%0d want=1", w); end
        total++; if (wSEL !== 1'b0) begin bad++; $display("FAIL basic_sel got=%b want=0", wSEL); end
        total++; if (wBUS_EN !== 1'b1) begin bad++; $display("FAIL basic_busen got=%b want=1", wBUS_EN); end
        rCS_n = 2'b10;
        rSCK  = 2'b10;
        #1;
        total++; if (wFLASH_CSn !== 1'b0) begin bad++; $display("FAIL basic_cs_pass got=%b want=0", wFLASH_CSn); end
        total++; if (wFLASH_SCK !== 1'b0) begin bad++; $display("FAIL basic_sck_block got=%b want=0", wFLASH_SCK); end
        rSCK = 2'b01;
        #1;
        total++; if (wFLASH_SCK !== 1'b1) begin bad++; $display("FAIL basic_sck_pass got=%b want=1", wFLASH_SCK); end
        rCS_n = 2'b11;
        rSCK  = 2'b00;
        rREQ  = 2'b00;
        tick();
        total++; if (wGNT !== 2'b00) begin bad++; $display("FAIL basic_release_gnt got=%b want=00", wGNT); end
        total++; if (wFLASH_CSn !== 1'b1) begin bad++; $display("FAIL basic_guard_csn got=%b want=1", wFLASH_CSn); end
        total++; if (wSEL !== 1'b0) begin bad++; $display("FAIL basic_guard_sel got=%b want=0", wSEL); end
        ticks(8);
    endtask

    task automatic test_round_robin();
        int w, c;
        logic [1:0] e;
        rRESETn = 1'b0;
        #2;
        rRESETn = 1'b1;
        tick();
        rREQ = 2'b11;
        expQ.push_back(2'b01);
        waitGrant(w, c);
        e = expQ.pop_front();
        total++; if (wGNT !== e) begin bad++; $display("FAIL rr_first_gnt got=%b want=%b", wGNT, e); end
        total++; if (w != 1) begin bad++; $display("FAIL rr_first_latency got=%0d want=1", w); end
        rCS_n = 2'b10;
        ticks(3);
        // Owner 0 releases while requester 1 keeps its raw CS low (must be gated).
        rREQ  = 2'b10;
        rCS_n = 2'b01;
        expQ.push_back(2'b10);
        waitGrant(w, c);
        e = expQ.pop_front();
        total++; if (wGNT !== e) begin bad++; $display("FAIL rr_second_gnt got=%b want=%b", wGNT, e); end
        total++; if (w != GuardCyc + 2) begin bad++; $display("FAIL rr_guard_wait got=%0d want=%0d", w, GuardCyc + 2); end
        total++; if (c != GuardCyc + 1) begin bad++; $display("FAIL rr_cs_high got=%0d want=%0d", c, GuardCyc + 1); end
        total++; if (wFLASH_CSn !== 1'b0) begin bad++; $display("FAIL rr_owner1_cs got=%b want=0", wFLASH_CSn); end
        rCS_n = 2'b11;
        rREQ  = 2'b00;
        tick();
        total++; if (wGNT !== 2'b00) begin bad++; $display("FAIL rr_release1_gnt got=%b want=00", wGNT); end
        total++; if (wSEL !== 1'b1) begin bad++; $display("FAIL rr_sel_hold got=%b want=1", wSEL); end
        // Requester 1 re-raises during its own guard and must lose the tie.
        rREQ = 2'b11;
        expQ.push_back(2'b01);
        waitGrant(w, c);
        e = expQ.pop_front();
        total++; if (wGNT !== e) begin bad++; $display("FAIL rr_third_gnt got=%b want=%b", wGNT, e); end
        total++; if (w != GuardCyc + 1) begin bad++; $display("FAIL rr_third_wait got=%0d want=%0d", w, GuardCyc + 1); end
        rREQ = 2'b00;
        ticks(10);
    endtask

    task automatic test_cs_hold();
        int w, c;
        logic [1:0] e;
        rREQ = 2'b10;
        expQ.push_back(2'b10);
        waitGrant(w, c);
        e = expQ.pop_front();
        total++; if (wGNT !== e) begin bad++; $display("FAIL hold_grant got=%b want=%b", wGNT, e); end
        rCS_n = 2'b01;
        ticks(2);
        rREQ = 2'b01;
        expQ.push_back(2'b01);
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (wGNT !== 2'b10) begin bad++; $display("FAIL hold_keep[%0d] got=%b want=10", i, wGNT); end
        end
        rCS_n = 2'b10;
        waitGrant(w, c);
        e = expQ.pop_front();
        total++; if (wGNT !== e) begin bad++; $display("FAIL hold_next_gnt got=%b want=%b", wGNT, e); end
        total++; if (c != GuardCyc + 1) begin bad++; $display("FAIL hold_cs_high got=%0d want=%0d", c, GuardCyc + 1); end
        total++; if (w != GuardCyc + 2) begin bad++; $display("FAIL hold_wait got=%0d want=%0d", w, GuardCyc + 2); end
        total++; if (wSEL !== 1'b0) begin bad++; $display("FAIL hold_sel got=%b want=0", wSEL); end
        rREQ  = 2'b00;
        rCS_n = 2'b11;
        ticks(10);
    endtask

    task automatic test_async_reset();
        int w, c;
        logic [1:0] e;
        rREQ = 2'b01;
        expQ.push_back(2'b01);
        waitGrant(w, c);
        e = expQ.pop_front();
        total++; if (wGNT !== e) begin bad++; $display("FAIL areset_pre_gnt got=%b want=%b", wGNT, e); end
        rCS_n = 2'b10;
        #1;
        total++; if (wFLASH_CSn !== 1'b0) begin bad++; $display("FAIL areset_pre_cs got=%b want=0", wFLASH_CSn); end
        #2;
        rRESETn = 1'b0;
        #1;
        total++; if (wFLASH_CSn !== 1'b1) begin bad++; $display("FAIL areset_cs got=%b want=1", wFLASH_CSn); end
        total++; if (wGNT !== 2'b00) begin bad++; $display("FAIL areset_gnt got=%b want=00", wGNT); end
        total++; if (wBUS_EN !== 1'b0) begin bad++; $display("FAIL areset_busen got=%b want=0", wBUS_EN); end
        rREQ  = 2'b00;
        rCS_n = 2'b11;
        #2;
        rRESETn = 1'b1;
        tick();
        rREQ = 2'b10;
        expQ.push_back(2'b10);
        waitGrant(w, c);
        e = expQ.pop_front();
        total++; if (wGNT !== e) begin bad++; $display("FAIL areset_post_gnt got=%b want=%b", wGNT, e); end
        total++; if (w != 1) begin bad++; $display("FAIL areset_post_latency got=%0d want=1", w); end
        rREQ = 2'b00;
        ticks(10);
    endtask

    task automatic test_preempt();
        int w, c;
        logic [1:0] e;
        rREQ = 2'b01;
        expQ.push_back(2'b01);
        waitGrant(w, c);
        e = expQ.pop_front();
        total++; if (wGNT !== e) begin bad++; $display("FAIL pre_grant got=%b want=%b", wGNT, e); end
        rCS_n = 2'b10;
        rREQ  = 2'b11;
        ticks(MaxHold - 1);
        total++; if (wPREEMPT !== 2'b00) begin bad++; $display("FAIL pre_early got=%b want=00", wPREEMPT); end
        tick();
        total++;
        if (wPREEMPT !== (PreemptOn ? 2'b01 : 2'b00)) begin
            bad++; $display("FAIL pre_raise got=%b want=%b", wPREEMPT, PreemptOn ? 2'b01 : 2'b00);
        end
        ticks(3);
        total++;
        if (wPREEMPT !== (PreemptOn ? 2'b01 : 2'b00)) begin
            bad++; $display("FAIL pre_stay got=%b want=%b", wPREEMPT, PreemptOn ? 2'b01 : 2'b00);
        end
        total++; if (wGNT !== 2'b01) begin bad++; $display("FAIL pre_no_revoke got=%b want=01", wGNT); end
        rREQ  = 2'b10;
        rCS_n = 2'b11;
        expQ.push_back(2'b10);
        tick();
        total++; if (wPREEMPT !== 2'b00) begin bad++; $display("FAIL pre_guard_clear got=%b want=00", wPREEMPT); end
        waitGrant(w, c);
        e = expQ.pop_front();
        total++; if (wGNT !== e) begin bad++; $display("FAIL pre_next_gnt got=%b want=%b", wGNT, e); end
        rREQ = 2'b00;
        ticks(10);
    endtask

    // Random requesters. Each raises iREQ, waits for its grant, then runs a CS-low burst.
    // Sometimes it drops iREQ early inside the burst. Raw CS/SCK are noisy while not owning.
    task automatic test_stress();
        int phase[2];
        int waitCnt[2];
        int len[2];
        logic idx;
        for (int n = 0; n < 2; n++) begin
            phase[n] = 0; waitCnt[n] = 0; len[n] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            total++; if (wGNT === 2'b11) begin bad++; $display("FAIL stress_onehot cyc=%0d got=%b want!=11", cyc, wGNT); end
            total++; if (wBUS_EN !== |wGNT) begin bad++; $display("FAIL stress_busen cyc=%0d got=%b want=%b", cyc, wBUS_EN, |wGNT); end
            if (wGNT == 2'b00) begin
                total++;
                if (wFLASH_CSn !== 1'b1 || wFLASH_SCK !== 1'b0) begin
                    bad++; $display("FAIL stress_idle_pins cyc=%0d got=%b%b want=10", cyc, wFLASH_CSn, wFLASH_SCK);
                end
            end else begin
                idx = wGNT[1];
                total++;
                if (wFLASH_CSn !== rCS_n[idx] || wFLASH_SCK !== rSCK[idx] || wSEL !== idx) begin
                    bad++; $display("FAIL stress_pass cyc=%0d got=%b%b%b want=%b%b%b", cyc, wFLASH_CSn,
                                    wFLASH_SCK, wSEL, rCS_n[idx], rSCK[idx], idx);
                end
            end
            for (int n = 0; n < 2; n++) begin
                case (phase[n])
                    0: begin
                        rCS_n[n] = 1'($urandom_range(0, 1));
                        rSCK[n]  = 1'($urandom_range(0, 1));
                        if ($urandom_range(0, 3) == 0) begin
                            rREQ[n] = 1'b1; phase[n] = 1; waitCnt[n] = 0;
                        end
                    end
                    1: begin
                        if (wGNT[n]) begin
                            total++;
                            if (waitCnt[n] > WaitBound) begin
                                bad++; $display("FAIL stress_wait req=%0d got=%0d want<=%0d", n, waitCnt[n], WaitBound);
                            end
                            phase[n] = 2;
                            len[n]   = $urandom_range(1, MaxTxn);
                            rCS_n[n] = 1'b0;
                        end else begin
                            waitCnt[n]++;
                            rCS_n[n] = 1'($urandom_range(0, 1));
                            rSCK[n]  = 1'($urandom_range(0, 1));
                            if (waitCnt[n] == WaitBound + 1) begin
                                total++; bad++;
                                $display("FAIL stress_starve req=%0d got=%0d want<=%0d", n, waitCnt[n], WaitBound);
                            end
                        end
                    end
                    default: begin
                        total++;
                        if (wGNT[n] !== 1'b1) begin
                            bad++; $display("FAIL stress_keep req=%0d cyc=%0d got=%b want=1", n, cyc, wGNT[n]);
                        end
                        rSCK[n] = 1'($urandom_range(0, 1));
                        if ($urandom_range(0, 7) == 0) rREQ[n] = 1'b0;
                        len[n]--;
                        if (len[n] == 0) begin
                            rCS_n[n] = 1'b1; rSCK[n] = 1'b0; rREQ[n] = 1'b0; phase[n] = 0;
                        end
                    end
                endcase
            end
        end
        rREQ  = 2'b00;
        rCS_n = 2'b11;
        rSCK  = 2'b00;
        ticks(10);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_cs_hold();
        test_async_reset();
        test_preempt();
        test_stress();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
